mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-port instruction/data memory between the fetch stage (P1) and the data-access stage (P4 LD/ST) of the pipelined processor. Each cycle it selects one requester, drives the memory address, data and write strobe, and routes the one-cycle-late read data back to the owner. It produces the fetch-stall signal that freezes PC/P1 while a data access holds the port. A bounded-run fairness counter prevents a stream of back-to-back loads and stores from starving fetch.

## Interface
Parameters:
- AW, 12, memory address width
- DW, 16, memory data width
- MAX_DATA_RUN, 4, max consecutive data grants while fetch waits (1..15)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch wants a read this cycle
- if_addr  in  AW  fetch address (PC)
- if_gnt  out  1  fetch owns the port this cycle
- if_stall  out  1  if_req & ~if_gnt; holds PC and P1
- if_rvalid  out  1  if_rdata valid (read granted previous cycle)
- if_rdata  out  DW  fetched instruction
- d_req  in  1  data access request (LD or ST)
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data owns the port this cycle
- d_rvalid  out  1  d_rdata valid (load granted previous cycle)
- d_rdata  out  DW  load data
- m_addr  out  AW  memory address
- m_data  out  DW  memory write data
- m_rw  out  1  1 = write, 0 = read
- m_q  in  DW  memory read data, valid one cycle after address

## Operation
- Grant is combinational from requests and the registered run counter run_cnt (0..MAX_DATA_RUN).
- Priority: data wins, except when run_cnt == MAX_DATA_RUN and if_req = 1; then fetch wins.
- Counter: d_gnt & if_req -> run_cnt+1; if_gnt or ~if_req -> 0. Saturates at MAX_DATA_RUN; never wraps.
- At most one of if_gnt/d_gnt is high; neither is high when neither request is high.
- Port mux: d_gnt -> m_addr=d_addr, m_rw=d_we, m_data=d_wdata; if_gnt -> m_addr=if_addr, m_rw=0; idle -> m_addr=0, m_rw=0, m_data=0.
- Return tag register: owner = {fetch, data-load, none} captured at the grant edge; stores set none.
- Next cycle: m_q is routed to if_rdata or d_rdata and the matching rvalid is asserted. The non-owning rdata holds its last value.
- Simultaneous if_req and d_req with no starvation pending: d_gnt=1, if_stall=1.
- A data-side starvation stall is not needed. P4 back-pressure is outside this block, so d_req must not be dropped by the arbiter.

## Timing
- Grant-to-memory latency is 0 cycles (combinational). Grant-to-rvalid latency is exactly 1 cycle. Throughput is one access per cycle.
- Reset values (asynchronous, on reset = 0): run_cnt=0, tag=none, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0. The combinational outputs follow the reset-state equations.
- Reset asserted mid-read: the pending return is discarded; no rvalid after release.
- Requesters hold address, data and we stable while req is high and not granted.

## Configuration
- MEM_ARB_FAIRNESS_EN defined: run_cnt and the forced fetch slot exist as described.
- Undefined: run_cnt is removed. Data has strict priority, and fetch may stall indefinitely under continuous d_req.

## Test plan
- Fetch only: if_req=1, if_addr=0x010, m_q=0xC0D1 next cycle -> if_gnt=1, m_addr=0x010, m_rw=0; next cycle if_rvalid=1, if_rdata=0xC0D1.
- Store: d_req=1, d_we=1, d_addr=0x0A5, d_wdata=0x1234, if_req=1 -> d_gnt=1, m_rw=1, m_addr=0x0A5, m_data=0x1234, if_stall=1; next cycle neither rvalid asserted.
- Load collision: if_req=d_req=1, d_we=0, d_addr=0x200 -> d_gnt; next cycle d_rvalid=1, d_rdata=m_q, if_rvalid=0.
- Starvation (MEM_ARB_FAIRNESS_EN, MAX_DATA_RUN=4): both requests held for 10 cycles -> grant pattern D,D,D,D,F,D,D,D,D,F.
- Reset: assert reset=0 in the cycle after a load grant -> d_rvalid stays 0; all registered outputs are 0 asynchronously.
- Idle: no requests -> m_rw=0, m_addr=0, both gnt=0, both rvalid=0 next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// Optional fetch-fairness slot is enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
    parameter int unsigned AW           = 12,
    parameter int unsigned DW           = 16,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_stall_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic [AW-1:0] m_addr_o,
    output logic [DW-1:0] m_data_o,
    output logic          m_rw_o,
    input  logic [DW-1:0] m_q_i
);

    localparam logic [1:0] TagNone  = 2'd0;
    localparam logic [1:0] TagFetch = 2'd1;
    localparam logic [1:0] TagLoad  = 2'd2;

    logic [1:0]    tag_q, tag_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          force_fetch;
    logic          if_gnt, d_gnt;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int unsigned RunW = 4;
    localparam logic [RunW-1:0] RunMax = RunW'(MAX_DATA_RUN);

    logic [RunW-1:0] run_cnt_q, run_cnt_d;

    assign force_fetch = if_req_i && (run_cnt_q == RunMax);

    // Counts data grants that made fetch wait; any fetch grant or idle fetch clears it.
    always_comb begin
        run_cnt_d = '0;
        if (d_gnt && if_req_i) begin
            run_cnt_d = (run_cnt_q == RunMax) ? run_cnt_q : run_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end
`else
    assign force_fetch = 1'b0;
`endif

    assign d_gnt      = d_req_i && !force_fetch;
    assign if_gnt     = if_req_i && !d_gnt;
    assign d_gnt_o    = d_gnt;
    assign if_gnt_o   = if_gnt;
    assign if_stall_o = if_req_i && !if_gnt;

    always_comb begin
        m_addr_o = '0;
        m_data_o = '0;
        m_rw_o   = 1'b0;
        if (d_gnt) begin
            m_addr_o = d_addr_i;
            m_data_o = d_wdata_i;
            m_rw_o   = d_we_i;
        end else if (if_gnt) begin
            m_addr_o = if_addr_i;
        end
    end

    always_comb begin
        tag_d = TagNone;
        if (if_gnt) begin
            tag_d = TagFetch;
        end else if (d_gnt && !d_we_i) begin
            tag_d = TagLoad;
        end
    end

    // Read data arrives a cycle after the grant; the non-owner keeps its last value.
    assign if_rvalid_o = (tag_q == TagFetch);
    assign d_rvalid_o  = (tag_q == TagLoad);
    assign if_rdata_d  = if_rvalid_o ? m_q_i : if_rdata_q;
    assign d_rdata_d   = d_rvalid_o ? m_q_i : d_rdata_q;
    assign if_rdata_o  = if_rdata_d;
    assign d_rdata_o   = d_rdata_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q      <= TagNone;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            tag_q      <= tag_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule
